// File: rtl/dm_access_arbiter.sv
// Round-robin two-port front end for the 32-byte big-endian data memory.
// Sub-word stores run as read-modify-write; misaligned/out-of-range commands return err without touching DM.
module dm_access_arbiter #(
  parameter int MEM_BYTES = 32,
  parameter int SIZE_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [SIZE_W-1:0] a_size,
  input  logic [31:0]       a_addr,
  input  logic [31:0]       a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [SIZE_W-1:0] b_size,
  input  logic [31:0]       b_addr,
  input  logic [31:0]       b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_done,
  output logic              b_done,
  output logic [31:0]       a_rdata,
  output logic [31:0]       b_rdata,
  output logic              a_err,
  output logic              b_err,
  output logic [31:0]       MemAddr,
  output logic [31:0]       MemWriteData,
  output logic              MemWrite,
  input  logic [31:0]       MemReadData
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP} state_t;

  localparam logic [SIZE_W-1:0] SZ_BYTE   = SIZE_W'(0);
  localparam logic [SIZE_W-1:0] SZ_HALF   = SIZE_W'(1);
  localparam logic [SIZE_W-1:0] SZ_WORD   = SIZE_W'(2);
  localparam logic [31:0]       MEM_LIMIT = 32'(MEM_BYTES);

  state_t            state_q, state_d;
  logic              rr_last_q, rr_last_d;   // 1 = B won the last tie
  logic              owner_q, owner_d;       // 1 = B owns the current access
  logic [SIZE_W-1:0] size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic              a_done_q, a_done_d, b_done_q, b_done_d;
  logic              a_err_q, a_err_d, b_err_q, b_err_d;
  logic [31:0]       a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [31:0]       mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;

  logic              pick_b;
  logic              cmd_we;
  logic [SIZE_W-1:0] cmd_size;
  logic [31:0]       cmd_addr, cmd_wdata;
  logic              cmd_err;
  logic [31:0]       lane;

  function automatic logic [31:0] load_lane(input logic [31:0] w, input logic [SIZE_W-1:0] sz,
                                            input logic [1:0] off);
    logic [31:0] r;
    r = w;
    if (sz == SZ_BYTE) begin
      case (off)
        2'd0:    r = {24'h0, w[31:24]};
        2'd1:    r = {24'h0, w[23:16]};
        2'd2:    r = {24'h0, w[15:8]};
        default: r = {24'h0, w[7:0]};
      endcase
    end else if (sz == SZ_HALF) begin
      r = off[1] ? {16'h0, w[15:0]} : {16'h0, w[31:16]};
    end
    return r;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [SIZE_W-1:0] sz,
                                             input logic [1:0] off, input logic [15:0] d);
    logic [31:0] r;
    r = w;
    if (sz == SZ_BYTE) begin
      case (off)
        2'd0:    r = {d[7:0], w[23:0]};
        2'd1:    r = {w[31:24], d[7:0], w[15:0]};
        2'd2:    r = {w[31:16], d[7:0], w[7:0]};
        default: r = {w[31:8], d[7:0]};
      endcase
    end else if (sz == SZ_HALF) begin
      r = off[1] ? {w[31:16], d} : {d, w[15:0]};
    end
    return r;
  endfunction

  // Command of whichever port would win arbitration this cycle, checked before any DM access.
  always_comb begin
    pick_b    = b_req && (!a_req || !rr_last_q);
    cmd_we    = pick_b ? b_we    : a_we;
    cmd_size  = pick_b ? b_size  : a_size;
    cmd_addr  = pick_b ? b_addr  : a_addr;
    cmd_wdata = pick_b ? b_wdata : a_wdata;
    cmd_err   = cmd_addr >= MEM_LIMIT;
    if (cmd_size == SZ_HALF)      cmd_err = cmd_err || cmd_addr[0];
    else if (cmd_size == SZ_WORD) cmd_err = cmd_err || (cmd_addr[1:0] != 2'b00);
    else if (cmd_size != SZ_BYTE) cmd_err = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    owner_d     = owner_q;
    size_d      = size_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    a_gnt_d     = a_gnt_q;
    b_gnt_d     = b_gnt_q;
    a_done_d    = 1'b0;
    b_done_d    = 1'b0;
    a_err_d     = 1'b0;
    b_err_d     = 1'b0;
    a_rdata_d   = '0;
    b_rdata_d   = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    lane        = load_lane(MemReadData, size_q, off_q);
    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          if (a_req && b_req) rr_last_d = pick_b;
          owner_d = pick_b;
          size_d  = cmd_size;
          off_d   = cmd_addr[1:0];
          wdata_d = cmd_wdata[15:0];
          a_gnt_d = !pick_b;
          b_gnt_d = pick_b;
          if (cmd_err) begin
            state_d  = S_RESP;
            a_done_d = !pick_b;
            b_done_d = pick_b;
            a_err_d  = !pick_b;
            b_err_d  = pick_b;
          end else begin
            mem_addr_d = {cmd_addr[31:2], 2'b00};
            if (!cmd_we) begin
              state_d = S_RD;
            end else if (cmd_size == SZ_WORD) begin
              state_d     = S_WR;
              mem_we_d    = 1'b1;
              mem_wdata_d = cmd_wdata;
            end else begin
              state_d = S_RMW_RD;
            end
          end
        end
      end
      S_RD: begin
        state_d   = S_RESP;
        a_done_d  = !owner_q;
        b_done_d  = owner_q;
        a_rdata_d = owner_q ? '0 : lane;
        b_rdata_d = owner_q ? lane : '0;
      end
      S_RMW_RD: begin
        state_d     = S_WR;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b1;
        mem_wdata_d = merge_lane(MemReadData, size_q, off_q, wdata_q);
      end
      S_WR: begin
        state_d  = S_RESP;
        a_done_d = !owner_q;
        b_done_d = owner_q;
      end
      S_RESP: begin
        state_d = S_IDLE;
        a_gnt_d = 1'b0;
        b_gnt_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_last_q   <= 1'b1;
      owner_q     <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      a_err_q     <= 1'b0;
      b_err_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      owner_q     <= owner_d;
      size_q      <= size_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_done_q    <= a_done_d;
      b_done_q    <= b_done_d;
      a_err_q     <= a_err_d;
      b_err_q     <= b_err_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign a_gnt        = a_gnt_q;
  assign b_gnt        = b_gnt_q;
  assign a_done       = a_done_q;
  assign b_done       = b_done_q;
  assign a_err        = a_err_q;
  assign b_err        = b_err_q;
  assign a_rdata      = a_rdata_q;
  assign b_rdata      = b_rdata_q;
  assign MemAddr      = mem_addr_q;
  assign MemWriteData = mem_wdata_q;
  assign MemWrite     = mem_we_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Bench for dm_access_arbiter: an 8-word DM model plus a scoreboard of expected completions.
module tb_dm_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [1:0]  a_size = '0, b_size = '0;
  logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic        a_gnt, b_gnt, a_done, b_done, a_err, b_err, MemWrite;
  logic [31:0] a_rdata, b_rdata, MemAddr, MemWriteData, MemReadData;

  logic [31:0] mem [8];
  logic        mem_ready = 1'b0;

  typedef struct {
    int          port;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    logic [31:0] wword;
  } cmd_t;

  cmd_t sb[$];
  int   checks = 0;
  int   failures = 0;

  dm_access_arbiter #(.MEM_BYTES(32), .SIZE_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_done(a_done), .b_done(b_done),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .a_err(a_err), .b_err(b_err),
    .MemAddr(MemAddr), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
    .MemReadData(MemReadData)
  );

  always #5 clk = ~clk;

  assign MemReadData = mem[MemAddr[4:2]];

  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 8; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
      mem[7]    <= 32'h8899_AABB;
      mem_ready <= 1'b1;
    end else if (MemWrite) begin
      mem[MemAddr[4:2]] <= MemWriteData;
    end
  end

  task automatic drive(input cmd_t c);
    if (c.port == 0) begin
      a_req = 1'b1; a_we = c.we; a_size = c.size; a_addr = c.addr; a_wdata = c.wdata;
    end else begin
      b_req = 1'b1; b_we = c.we; b_size = c.size; b_addr = c.addr; b_wdata = c.wdata;
    end
  endtask

  task automatic drop_all();
    a_req = 1'b0; a_we = 1'b0; a_size = '0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_size = '0; b_addr = '0; b_wdata = '0;
  endtask

  // Index 0 is the negedge of the IDLE cycle whose closing posedge samples the request.
  task automatic observe(output int port, output logic [31:0] rdata, output logic err,
                         output int lat, output int nwr, output logic [31:0] waddr,
                         output logic [31:0] wword, output logic excl);
    port = -1; rdata = '0; err = 1'b0; lat = -1; nwr = 0; waddr = '0; wword = '0; excl = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (MemWrite) begin
        nwr++; waddr = MemAddr; wword = MemWriteData;
      end
      if (a_done || b_done) begin
        port  = a_done ? 0 : 1;
        lat   = k;
        rdata = a_done ? a_rdata : b_rdata;
        err   = a_done ? a_err : b_err;
        excl  = a_done ? (a_gnt && !b_gnt && !b_done && !b_err && b_rdata == 32'h0)
                       : (b_gnt && !a_gnt && !a_done && !a_err && a_rdata == 32'h0);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drop_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt, a_done, b_done, a_err, b_err, MemWrite} !== 7'b0) begin
      failures++;
      $display("FAIL reset flags: got %b expected 0000000",
               {a_gnt, b_gnt, a_done, b_done, a_err, b_err, MemWrite});
    end
    checks++;
    if ({a_rdata, b_rdata} !== 64'h0) begin
      failures++; $display("FAIL reset rdata: got %h/%h expected 0", a_rdata, b_rdata);
    end
    checks++;
    if (MemAddr !== 32'h0) begin
      failures++; $display("FAIL reset MemAddr: got %h expected 0", MemAddr);
    end
    checks++;
    if (MemWriteData !== 32'h0) begin
      failures++; $display("FAIL reset MemWriteData: got %h expected 0", MemWriteData);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_word_access();
    cmd_t tbl[2];
    cmd_t e;
    int p, lat, nwr;
    logic [31:0] rd, wa, ww;
    logic er, ex;
    tbl[0] = '{0, 1'b1, 2'd2, 32'd4, 32'h1122_3344, 32'h0, 1'b0, 2, 1, 32'h1122_3344};
    tbl[1] = '{0, 1'b0, 2'd2, 32'd4, 32'h0, 32'h1122_3344, 1'b0, 2, 0, 32'h0};
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      observe(p, rd, er, lat, nwr, wa, ww, ex);
      drop_all();
      e = sb.pop_front();
      checks++; if (p !== e.port) begin failures++; $display("FAIL word[%0d] port: got %0d expected %0d", i, p, e.port); end
      checks++; if (lat !== e.lat) begin failures++; $display("FAIL word[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL word[%0d] rdata: got %h expected %h", i, rd, e.rdata); end
      checks++; if (er !== e.err) begin failures++; $display("FAIL word[%0d] err: got %b expected %b", i, er, e.err); end
      checks++; if (nwr !== e.nwr) begin failures++; $display("FAIL word[%0d] MemWrite cycles: got %0d expected %0d", i, nwr, e.nwr); end
      checks++; if (ex !== 1'b1) begin failures++; $display("FAIL word[%0d] grant/loser outputs: got %b expected 1", i, ex); end
      if (e.nwr == 1) begin
        checks++; if (wa !== {e.addr[31:2], 2'b00}) begin failures++; $display("FAIL word[%0d] MemAddr: got %h expected %h", i, wa, {e.addr[31:2], 2'b00}); end
        checks++; if (ww !== e.wword) begin failures++; $display("FAIL word[%0d] MemWriteData: got %h expected %h", i, ww, e.wword); end
      end
    end
    checks++;
    if (mem[1] !== 32'h1122_3344) begin
      failures++; $display("FAIL word mem[1]: got %h expected 11223344", mem[1]);
    end
  endtask

  task automatic test_subword_access();
    cmd_t tbl[9];
    cmd_t e;
    int p, lat, nwr;
    logic [31:0] rd, wa, ww;
    logic er, ex;
    tbl[0] = '{1, 1'b1, 2'd0, 32'd6,  32'h0000_00AA, 32'h0, 1'b0, 3, 1, 32'h1122_AA44};
    tbl[1] = '{1, 1'b0, 2'd1, 32'd6,  32'h0, 32'h0000_AA44, 1'b0, 2, 0, 32'h0};
    tbl[2] = '{1, 1'b0, 2'd0, 32'd7,  32'h0, 32'h0000_0044, 1'b0, 2, 0, 32'h0};
    tbl[3] = '{0, 1'b0, 2'd0, 32'd4,  32'h0, 32'h0000_0011, 1'b0, 2, 0, 32'h0};
    tbl[4] = '{0, 1'b1, 2'd1, 32'd4,  32'h0000_BEEF, 32'h0, 1'b0, 3, 1, 32'hBEEF_AA44};
    tbl[5] = '{0, 1'b1, 2'd0, 32'd5,  32'hFFFF_FF12, 32'h0, 1'b0, 3, 1, 32'hBE12_AA44};
    tbl[6] = '{0, 1'b0, 2'd2, 32'd4,  32'h0, 32'hBE12_AA44, 1'b0, 2, 0, 32'h0};
    tbl[7] = '{1, 1'b0, 2'd0, 32'd31, 32'h0, 32'h0000_00BB, 1'b0, 2, 0, 32'h0};
    tbl[8] = '{0, 1'b0, 2'd1, 32'd30, 32'h0, 32'h0000_AABB, 1'b0, 2, 0, 32'h0};
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      observe(p, rd, er, lat, nwr, wa, ww, ex);
      drop_all();
      e = sb.pop_front();
      checks++; if (p !== e.port) begin failures++; $display("FAIL sub[%0d] port: got %0d expected %0d", i, p, e.port); end
      checks++; if (lat !== e.lat) begin failures++; $display("FAIL sub[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL sub[%0d] rdata: got %h expected %h", i, rd, e.rdata); end
      checks++; if (er !== e.err) begin failures++; $display("FAIL sub[%0d] err: got %b expected %b", i, er, e.err); end
      checks++; if (nwr !== e.nwr) begin failures++; $display("FAIL sub[%0d] MemWrite cycles: got %0d expected %0d", i, nwr, e.nwr); end
      checks++; if (ex !== 1'b1) begin failures++; $display("FAIL sub[%0d] grant/loser outputs: got %b expected 1", i, ex); end
      if (e.nwr == 1) begin
        checks++; if (wa !== {e.addr[31:2], 2'b00}) begin failures++; $display("FAIL sub[%0d] MemAddr: got %h expected %h", i, wa, {e.addr[31:2], 2'b00}); end
        checks++; if (ww !== e.wword) begin failures++; $display("FAIL sub[%0d] MemWriteData: got %h expected %h", i, ww, e.wword); end
      end
    end
  endtask

  task automatic test_errors();
    cmd_t tbl[5];
    cmd_t e;
    int p, lat, nwr;
    logic [31:0] rd, wa, ww;
    logic er, ex;
    tbl[0] = '{0, 1'b0, 2'd2, 32'd2,  32'h0, 32'h0, 1'b1, 1, 0, 32'h0};
    tbl[1] = '{1, 1'b1, 2'd1, 32'd9,  32'h0000_1234, 32'h0, 1'b1, 1, 0, 32'h0};
    tbl[2] = '{0, 1'b0, 2'd2, 32'd32, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0};
    tbl[3] = '{1, 1'b0, 2'd3, 32'd0,  32'h0, 32'h0, 1'b1, 1, 0, 32'h0};
    tbl[4] = '{0, 1'b1, 2'd0, 32'd40, 32'h0000_0077, 32'h0, 1'b1, 1, 0, 32'h0};
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      observe(p, rd, er, lat, nwr, wa, ww, ex);
      drop_all();
      e = sb.pop_front();
      checks++; if (p !== e.port) begin failures++; $display("FAIL err[%0d] port: got %0d expected %0d", i, p, e.port); end
      checks++; if (lat !== e.lat) begin failures++; $display("FAIL err[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL err[%0d] rdata: got %h expected %h", i, rd, e.rdata); end
      checks++; if (er !== e.err) begin failures++; $display("FAIL err[%0d] err: got %b expected %b", i, er, e.err); end
      checks++; if (nwr !== e.nwr) begin failures++; $display("FAIL err[%0d] MemWrite cycles: got %0d expected %0d", i, nwr, e.nwr); end
      checks++; if (ex !== 1'b1) begin failures++; $display("FAIL err[%0d] grant/loser outputs: got %b expected 1", i, ex); end
    end
    checks++;
    if (mem[0] !== 32'hA5A5_0000) begin
      failures++; $display("FAIL err mem[0]: got %h expected a5a50000", mem[0]);
    end
    checks++;
    if (mem[2] !== 32'hA5A5_0002) begin
      failures++; $display("FAIL err mem[2]: got %h expected a5a50002", mem[2]);
    end
  endtask

  task automatic test_arbitration();
    cmd_t ca, cb, e;
    int p, lat, nwr;
    logic [31:0] rd, wa, ww;
    logic er, ex;
    ca = '{0, 1'b0, 2'd2, 32'd4,  32'h0, 32'hBE12_AA44, 1'b0, 2, 0, 32'h0};
    cb = '{1, 1'b0, 2'd2, 32'd28, 32'h0, 32'h8899_AABB, 1'b0, 2, 0, 32'h0};
    test_reset();
    @(posedge clk); #1;
    drive(ca);
    drive(cb);
    sb.push_back(ca); sb.push_back(cb); sb.push_back(ca); sb.push_back(cb);
    for (int i = 0; i < 4; i++) begin
      observe(p, rd, er, lat, nwr, wa, ww, ex);
      if (i == 3) drop_all();
      e = sb.pop_front();
      checks++; if (p !== e.port) begin failures++; $display("FAIL arb[%0d] winner: got %0d expected %0d", i, p, e.port); end
      checks++; if (lat !== e.lat) begin failures++; $display("FAIL arb[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL arb[%0d] rdata: got %h expected %h", i, rd, e.rdata); end
      checks++; if (ex !== 1'b1) begin failures++; $display("FAIL arb[%0d] grant/loser outputs: got %b expected 1", i, ex); end
    end
  endtask

  task automatic test_reset_midop();
    cmd_t cs, cl, e;
    int events, p, lat, nwr;
    logic [31:0] rd, wa, ww;
    logic er, ex;
    cs = '{1, 1'b1, 2'd0, 32'd4, 32'h0000_0055, 32'h0, 1'b0, 3, 1, 32'h0};
    cl = '{0, 1'b0, 2'd2, 32'd4, 32'h0, 32'hBE12_AA44, 1'b0, 2, 0, 32'h0};
    events = 0;
    @(posedge clk); #1;
    drive(cs);
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (a_done || b_done || MemWrite) events++;
    end
    drop_all();
    rst_n = 1'b1;
    checks++;
    if (events !== 0) begin
      failures++; $display("FAIL midop done/MemWrite events: got %0d expected 0", events);
    end
    checks++;
    if ({a_gnt, b_gnt} !== 2'b00) begin
      failures++; $display("FAIL midop gnt: got %b expected 00", {a_gnt, b_gnt});
    end
    checks++;
    if (mem[1] !== 32'hBE12_AA44) begin
      failures++; $display("FAIL midop mem[1]: got %h expected be12aa44", mem[1]);
    end
    @(posedge clk); #1;
    drive(cl);
    sb.push_back(cl);
    observe(p, rd, er, lat, nwr, wa, ww, ex);
    drop_all();
    e = sb.pop_front();
    checks++; if (p !== e.port) begin failures++; $display("FAIL midop reload port: got %0d expected %0d", p, e.port); end
    checks++; if (lat !== e.lat) begin failures++; $display("FAIL midop reload latency: got %0d expected %0d", lat, e.lat); end
    checks++; if (rd !== e.rdata) begin failures++; $display("FAIL midop reload rdata: got %h expected %h", rd, e.rdata); end
    checks++; if (er !== e.err) begin failures++; $display("FAIL midop reload err: got %b expected %b", er, e.err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_access();
    test_subword_access();
    test_errors();
    test_arbitration();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_access_arbiter.md
Name: dm_access_arbiter

Overview:
- Two-port access controller and arbiter in front of the 32-byte big-endian data memory (DM).
- Shares DM between requester A (CPU load/store unit) and requester B (debug/DMA loader) using round-robin arbitration.
- DM only moves aligned 32-bit words, so this block sequences byte and halfword stores as read-modify-write.
- Checks alignment and range before any DM access and returns an error instead of touching memory.

Parameters:
- MEM_BYTES, 32, DM size in bytes; legal addresses are 0..MEM_BYTES-1.
- SIZE_W, 2, width of the access-size field; 0 = byte, 1 = half, 2 = word, 3 = reserved.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- a_req, b_req  in  1  request; held high with the command stable until done.
- a_we, b_we  in  1  1 = store, 0 = load.
- a_size, b_size  in  SIZE_W  access size.
- a_addr, b_addr  in  32  byte address.
- a_wdata, b_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- a_gnt, b_gnt  out  1  high from acceptance through the done cycle.
- a_done, b_done  out  1  one-cycle completion pulse.
- a_rdata, b_rdata  out  32  load data, zero-extended; valid only with done.
- a_err, b_err  out  1  error flag; valid only with done.
- MemAddr  out  32  DM address, always word-aligned.
- MemWriteData  out  32  DM write word.
- MemWrite  out  1  DM write enable; DM commits at the negedge within the cycle.
- MemReadData  in  32  DM combinational read word.

Behaviour:
- Reset: the following clear to 0 at the posedge where rst_n = 0:
  - state to IDLE;
  - all gnt, done, err, rdata outputs;
  - MemAddr, MemWriteData, MemWrite;
  - rr_last set to B, so A wins the first tie.
- Reset mid-operation: any in-flight access is abandoned with no done pulse. A write in a WR cycle whose negedge precedes the reset edge still commits.
- FSM states: IDLE, RD, RMW_RD, WR, RESP.
- IDLE, arbitration:
  - Only one request pending: grant it.
  - Both pending: grant the port not equal to rr_last, then set rr_last to the winner.
  - Latch the winner's we, size, addr and wdata; assert its gnt from the next cycle.
- Error check, done in IDLE on the latched command. An error is any of:
  - size == 3;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr >= MEM_BYTES.
  On error go to RESP with err = 1 and rdata = 0; MemWrite is never asserted.
- IDLE next state when there is no error:
  - load goes to RD;
  - word store goes to WR;
  - byte or half store goes to RMW_RD.
- Addressing: MemAddr = {addr[31:2], 2'b00} for RD, RMW_RD and WR, and 0 in IDLE/RESP.
- Lane mapping is big-endian:
  - byte offset 0 is bits [31:24], offset 3 is bits [7:0];
  - half offset 0 is bits [31:16], offset 2 is bits [15:0].
- RD: capture MemReadData, extract the lane, zero-extend into the rdata register, go to RESP.
- RMW_RD: capture MemReadData, replace the target lane with wdata[7:0] or [15:0], go to WR.
- WR: MemWrite = 1 for exactly this cycle, MemWriteData = merged or full word, go to RESP.
- RESP: winner's done = 1, rdata and err presented; gnt drops after this cycle; go to IDLE.
- Latency, from the posedge sampling req in IDLE to the done cycle:
  - error: 1 cycle;
  - load or word store: 2 cycles;
  - byte/half store: 3 cycles.
- Back-to-back requests:
  - A req still high in the IDLE cycle after RESP is a new request.
  - A requester must drop req in the cycle after done.
  - Minimum issue interval is one IDLE cycle between accesses.
- The losing requester simply waits, with no timeout. Round-robin bounds its wait to one access.
- MemWrite is never high outside WR. Loser outputs stay 0.

Test Plan:
- Reset, then A word store addr 4 data 0x11223344 → done at +2 cycles, one MemWrite cycle, MemAddr 4; then A word load addr 4 → rdata 0x11223344, err 0.
- B byte store addr 6 data 0x000000AA over word 0x11223344 → RMW, WR data 0x1122AA44; B half load addr 6 → 0x0000AA44; byte load addr 7 → 0x00000044.
- A and B both request on the same edge after reset → A served first, B next; repeat with both held → grants alternate A, B, A, B.
- Error cases: word load addr 2, half store addr 9, word load addr 32, size 3 → each done at +1 with err 1, rdata 0, MemWrite never high, memory unchanged.
- Assert rst_n = 0 during the RMW_RD cycle of a byte store → state IDLE, no done, no MemWrite, target word unchanged; a subsequent word load returns the original value.
